// File: rtl/bresenham_point_streamer.sv
// Bresenham point streamer: captures one parallel burst of line points and
// replays the valid lanes, lowest lane first, over a valid/ready stream.
// Each emitted point carries step/direction/jump flags relative to the
// previously emitted point, which persists across bursts.
//
// Stream handshake: a point transfers in any cycle where o_pt_valid and
// i_pt_ready are both high. o_pt_valid depends only on registered state, and
// while it is high and i_pt_ready is low every point output holds stable.
module bresenham_point_streamer #(
    parameter int P_MAX_LINE_LENGTH = 10,
    parameter int P_X_COORD_W       = 11,
    parameter int P_Y_COORD_W       = 10
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] i_x_vals,
    input  logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] i_y_vals,
    input  logic [P_MAX_LINE_LENGTH-1:0]           i_vals_valid,
    input  logic                                   i_vals_rdy,
    output logic                                   o_busy,
    output logic                                   o_overrun,
    output logic                                   o_pt_valid,
    input  logic                                   i_pt_ready,
    output logic [P_X_COORD_W-1:0]                 o_x,
    output logic [P_Y_COORD_W-1:0]                 o_y,
    output logic                                   o_x_step,
    output logic                                   o_x_dir,
    output logic                                   o_y_step,
    output logic                                   o_y_dir,
    output logic                                   o_jump,
    output logic                                   o_last,
    output logic                                   o_done
);

    localparam int XW = P_X_COORD_W;
    localparam int YW = P_Y_COORD_W;
    localparam int NL = P_MAX_LINE_LENGTH;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state;
    logic [NL*XW-1:0]      x_r;
    logic [NL*YW-1:0]      y_r;
    logic [NL-1:0]         mask_r;
    logic [XW-1:0]         prev_x;
    logic [YW-1:0]         prev_y;
    logic                  prev_valid;
    logic                  done_r;
    logic                  overrun_r;

    logic [XW-1:0]         cur_x;
    logic [YW-1:0]         cur_y;
    logic                  last_lane;
    logic [XW:0]           dx;
    logic [YW:0]           dy;
    logic [XW:0]           adx;
    logic [YW:0]           ady;
    logic                  x_step;
    logic                  y_step;
    logic                  pt_valid;

    // Priority-select the lowest remaining lane's coordinates.
    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (mask_r[i]) begin
                cur_x = x_r[i*XW +: XW];
                cur_y = y_r[i*YW +: YW];
            end
        end
    end

    // Exactly one lane left means the current point closes the burst.
    assign last_lane = (mask_r != '0) && ((mask_r & (mask_r - 1'b1)) == '0);

    // Signed deltas one bit wider than the coordinates, plus magnitudes.
    always_comb begin
        dx  = {1'b0, cur_x} - {1'b0, prev_x};
        dy  = {1'b0, cur_y} - {1'b0, prev_y};
        adx = dx[XW] ? (~dx + 1'b1) : dx;
        ady = dy[YW] ? (~dy + 1'b1) : dy;
    end

    assign pt_valid = (state == EMIT);
    assign x_step   = prev_valid && (dx != '0);
    assign y_step   = prev_valid && (dy != '0);

    // Point outputs are forced to zero whenever no point is offered.
    always_comb begin
        o_pt_valid = pt_valid;
        o_busy     = pt_valid;
        o_done     = done_r;
        o_overrun  = overrun_r;
        o_x        = pt_valid ? cur_x : '0;
        o_y        = pt_valid ? cur_y : '0;
        o_x_step   = pt_valid && x_step;
        o_x_dir    = pt_valid && x_step && !dx[XW];
        o_y_step   = pt_valid && y_step;
        o_y_dir    = pt_valid && y_step && !dy[YW];
        o_jump     = pt_valid && prev_valid && ((adx > 1) || (ady > 1));
        o_last     = pt_valid && last_lane;
    end

    // Burst capture, per-point transfer bookkeeping and status pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            mask_r     <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_vals_rdy) begin
                        x_r    <= i_x_vals;
                        y_r    <= i_y_vals;
                        mask_r <= i_vals_valid;
                        if (i_vals_valid != '0) begin
                            state <= EMIT;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (i_vals_rdy) begin
                        overrun_r <= 1'b1;
                    end
                    if (i_pt_ready) begin
                        // Clearing the lowest set bit retires the current lane.
                        mask_r     <= mask_r & (mask_r - 1'b1);
                        prev_x     <= cur_x;
                        prev_y     <= cur_y;
                        prev_valid <= 1'b1;
                        if (last_lane) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_point_streamer.sv
// Directed bench for bresenham_point_streamer: a table of expected points
// consumed in order, plus hand-written sequences for the multi-cycle cases.
module tb_bresenham_point_streamer;

    localparam int NL = 10;
    localparam int XW = 11;
    localparam int YW = 10;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          xs;
        logic          xd;
        logic          ys;
        logic          yd;
        logic          j;
        logic          l;
    } pt_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NL*XW-1:0]  xv  = '0;
    logic [NL*YW-1:0]  yv  = '0;
    logic [NL-1:0]     mask = '0;
    logic              vals_rdy = 1'b0;
    logic              pt_ready = 1'b0;
    logic              busy, overrun, pt_valid, x_step, x_dir, y_step, y_dir, jump, last, done;
    logic [XW-1:0]     ox;
    logic [YW-1:0]     oy;

    int total = 0;
    int bad   = 0;
    int exp_idx = 0;
    pt_t exp_tab[$];

    bresenham_point_streamer #(
        .P_MAX_LINE_LENGTH(NL), .P_X_COORD_W(XW), .P_Y_COORD_W(YW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_x_vals(xv), .i_y_vals(yv),
        .i_vals_valid(mask), .i_vals_rdy(vals_rdy), .o_busy(busy),
        .o_overrun(overrun), .o_pt_valid(pt_valid), .i_pt_ready(pt_ready),
        .o_x(ox), .o_y(oy), .o_x_step(x_step), .o_x_dir(x_dir),
        .o_y_step(y_step), .o_y_dir(y_dir), .o_jump(jump), .o_last(last),
        .o_done(done)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic add(input int x, input int y, input bit xs, input bit xd,
                       input bit ys, input bit yd, input bit j, input bit l);
        pt_t p;
        p.x = XW'(x); p.y = YW'(y);
        p.xs = xs; p.xd = xd; p.ys = ys; p.yd = yd; p.j = j; p.l = l;
        exp_tab.push_back(p);
    endtask

    task automatic set_lane(input int i, input int x, input int y);
        xv[i*XW +: XW] = XW'(x);
        yv[i*YW +: YW] = YW'(y);
    endtask

    // Pulse the strobe for one cycle; returns #1 after the capturing edge.
    task automatic strobe(input logic [NL-1:0] m);
        mask     = m;
        vals_rdy = 1'b1;
        @(posedge clk); #1;
        vals_rdy = 1'b0;
    endtask

    // Consume n points, comparing each offered point against the table.
    // toggle=1 drives ready 1,0,1,0...; stalled points must match too.
    task automatic drain(input int n, input bit toggle);
        int got = 0;
        int cyc = 0;
        pt_t g;
        pt_t w;
        while (got < n && cyc < 4 * n + 4) begin
            pt_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            chk("pt_valid", pt_valid, 1);
            g = {ox, oy, x_step, x_dir, y_step, y_dir, jump, last};
            w = exp_tab[exp_idx];
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL pt%0d: got x=%0d y=%0d ann=%b want x=%0d y=%0d ann=%b",
                         exp_idx, g.x, g.y, {g.xs, g.xd, g.ys, g.yd, g.j, g.l},
                         w.x, w.y, {w.xs, w.xd, w.ys, w.yd, w.j, w.l});
            end
            if (pt_valid && pt_ready) begin
                got++;
                exp_idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_count", got, n);
        chk("drain_cycles", cyc, toggle ? 2 * n - 1 : n);
    endtask

    task automatic chk_done_cycle(input string name);
        chk({name, "_done"}, done, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_valid"}, pt_valid, 0);
    endtask

    initial begin
        // Expected points, in emission order.
        // Burst 1: (5,5)..(0,0), first has no previous point.
        add(5, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i >= 0; i--) add(i, i, 1, 0, 1, 0, 0, i == 0);
        // Burst 2: (1,0)..(10,0) after (0,0).
        for (int i = 1; i <= 10; i++) add(i, 0, 1, 1, 0, 0, 0, i == 10);
        // Burst 3: sparse (0,0),(1,1),(3,3) after (10,0).
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 1, 0, 0);
        add(3, 3, 1, 1, 1, 1, 1, 1);
        // Burst 5: (20,30),(21,30),(21,29) after (3,3).
        add(20, 30, 1, 1, 1, 1, 1, 0);
        add(21, 30, 1, 1, 0, 0, 0, 0);
        add(21, 29, 0, 0, 1, 0, 0, 1);
        // Burst 6: first two of (50+i,50) after (21,29), then reset.
        add(50, 50, 1, 1, 1, 1, 1, 0);
        add(51, 50, 1, 1, 0, 0, 0, 0);
        // Burst 7: single point after reset, no previous point.
        add(7, 8, 0, 0, 0, 0, 0, 1);

        // Reset
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs",
            {busy, overrun, pt_valid, ox, oy, x_step, x_dir, y_step, y_dir, jump, last, done}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Burst 1: diagonal down, ready held high.
        for (int i = 0; i < 6; i++) set_lane(i, 5 - i, 5 - i);
        strobe(10'b0000111111);
        chk("b1_latency_valid", pt_valid, 1);
        chk("b1_busy", busy, 1);
        drain(6, 1'b0);
        chk_done_cycle("b1");

        // Burst 2, strobed on the done cycle, ready toggling.
        for (int i = 0; i < NL; i++) set_lane(i, i + 1, 0);
        strobe(10'b1111111111);
        drain(10, 1'b1);
        chk_done_cycle("b2");

        // Burst 3: sparse mask.
        xv = '0; yv = '0;
        set_lane(0, 0, 0); set_lane(1, 1, 1); set_lane(2, 77, 77); set_lane(3, 3, 3);
        strobe(10'b0000001011);
        drain(3, 1'b0);
        chk_done_cycle("b3");
        pt_ready = 1'b0;
        @(posedge clk); #1;

        // Empty burst: done only.
        strobe(10'b0000000000);
        chk_done_cycle("empty");
        @(posedge clk); #1;
        chk("empty_done_pulse", done, 0);
        chk("empty_valid_after", pt_valid, 0);

        // Burst 5 with a strobe arriving mid-burst.
        set_lane(0, 20, 30); set_lane(1, 21, 30); set_lane(2, 21, 29);
        strobe(10'b0000000111);
        pt_ready = 1'b0;
        for (int i = 0; i < NL; i++) set_lane(i, 999, 500);
        strobe(10'b1111111111);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_hold_x", ox, 20);
        @(posedge clk); #1;
        chk("ovr_once", overrun, 0);
        drain(3, 1'b0);
        chk_done_cycle("b5");
        chk("ovr_no_repeat", overrun, 0);

        // Burst 6 interrupted by reset after two transfers.
        for (int i = 0; i < 6; i++) set_lane(i, 50 + i, 50);
        strobe(10'b0000111111);
        drain(2, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_outputs",
            {busy, overrun, pt_valid, ox, oy, x_step, x_dir, y_step, y_dir, jump, last, done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", {done, pt_valid}, 0);
        end

        // Burst 7: first point after reset has no annotations.
        set_lane(0, 7, 8);
        strobe(10'b0000000001);
        drain(1, 1'b0);
        chk_done_cycle("b7");

        chk("table_consumed", exp_idx, exp_tab.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bresenham_point_streamer.md
Name: bresenham_point_streamer

Overview:
- Downstream stage of the bresenham line generator.
- Captures one parallel burst of up to P_MAX_LINE_LENGTH line points (x/y vectors plus per-lane valid mask) when the generator pulses its ready strobe.
- Emits the valid points one per handshake on a valid/ready stream, in lane order.
- Annotates each point with per-axis step/direction relative to the previously emitted point, for the motion/step driver.

Parameters:
P_MAX_LINE_LENGTH, 10, number of point lanes in the input vectors
P_X_COORD_W, 11, x coordinate width
P_Y_COORD_W, 10, y coordinate width

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous active-high reset
i_x_vals  input  P_MAX_LINE_LENGTH*P_X_COORD_W  lane i x at bits [i*P_X_COORD_W +: P_X_COORD_W]
i_y_vals  input  P_MAX_LINE_LENGTH*P_Y_COORD_W  lane i y, same packing
i_vals_valid  input  P_MAX_LINE_LENGTH  bit i = lane i holds a point
i_vals_rdy  input  1  one-cycle strobe: vectors are valid this cycle
o_busy  output  1  burst held; new strobes rejected
o_overrun  output  1  one-cycle pulse: strobe arrived while busy, burst dropped
o_pt_valid  output  1  point available
i_pt_ready  input  1  consumer accepts point
o_x  output  P_X_COORD_W  point x
o_y  output  P_Y_COORD_W  point y
o_x_step  output  1  x differs from previous emitted point
o_x_dir  output  1  1 = x increased, 0 = decreased or unchanged
o_y_step  output  1  y differs from previous emitted point
o_y_dir  output  1  1 = y increased, 0 = decreased or unchanged
o_jump  output  1  |dx|>1 or |dy|>1 versus previous point
o_last  output  1  current point is the last valid lane of the burst
o_done  output  1  one-cycle pulse after the last point transfers, or for an empty burst

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; internal mask, vector registers, previous-point registers and prev_valid all cleared.
- States:
  - IDLE: o_busy=0.
  - EMIT: o_busy=1.
- Capture: i_vals_rdy high in IDLE latches i_x_vals, i_y_vals and i_vals_valid into internal registers.
  - Non-zero mask: go to EMIT. o_pt_valid rises the next cycle (1-cycle latency).
  - Zero mask: stay IDLE and pulse o_done the next cycle. No point is emitted.
- Lane select: the current lane is the lowest set bit of the remaining-mask register (priority encoder). o_x, o_y and all annotations are driven from that lane and the previous-point registers.
- Transfer: o_pt_valid && i_pt_ready in one cycle.
  - On transfer: clear that lane's bit, load the previous-point registers with (o_x, o_y), set prev_valid.
  - If it was the last lane: go to IDLE next cycle and pulse o_done that same next cycle.
- Output stability: while o_pt_valid=1 and i_pt_ready=0, all point outputs hold stable.
- o_last: high exactly when the remaining mask has one bit set.
- Annotation arithmetic: dx = cur - prev, computed signed, one bit wider than the coordinate.
  - step = (dx != 0).
  - dir = (dx > 0).
  - jump = (|dx| > 1) on either axis.
  - When prev_valid=0 (first point after reset), step, dir and jump are all 0.
  - Previous point carries across bursts: the first point of a burst is compared with the last point of the prior burst.
- Coordinates are unsigned. There is no wrap handling: 0 versus max is a jump.
- Busy strobe: i_vals_rdy while in EMIT is ignored, the burst in progress is unaffected, and o_overrun pulses the next cycle.
- Strobe on the done cycle: i_vals_rdy in the same cycle o_done is high is accepted, because the state is already IDLE.
- Reset mid-burst: aborts immediately. No o_done; the remaining points are lost.
- Size: no combinational path from i_pt_ready to o_pt_valid. Target is about 200 lines of RTL.

Test Plan:
- Reset, then strobe mask 10'b0000111111 with lanes (5,5),(4,4),(3,3),(2,2),(1,1),(0,0) and i_pt_ready=1:
  - Six points on consecutive cycles starting 1 cycle after the strobe.
  - First point has step=0.
  - Remaining points have x_step=y_step=1, x_dir=y_dir=0.
  - o_last on (0,0); o_done one cycle later; o_busy low with o_done.
- Next burst (0,0)->(10,0), mask 10'b1111111111 (lane i = (i+1,0)), with i_pt_ready toggling 1,0,1,0:
  - Each point holds while ready=0.
  - Each point has x_step=1, x_dir=1, y_step=0.
  - First point (1,0) compares against prior (0,0): no jump.
- Sparse mask 10'b0000001011, lanes 0,1,3 = (0,0),(1,1),(3,3):
  - Exactly three points emitted.
  - (3,3) has o_jump=1 and o_last=1.
- Strobe with mask 0: o_done pulses 1 cycle later, o_pt_valid stays 0, o_busy stays 0.
- Strobe during EMIT with different data:
  - o_overrun pulses once.
  - The original points complete unchanged; the new data never appears.
- Assert i_reset after 2 of 6 points transfer:
  - All outputs 0 immediately, no o_done.
  - The next burst's first point has step=0.
